// File: rtl/data_mem_sync.sv
// Single-port data memory with a fixed access latency of WAIT_CYCLES+1 clocks.
// One request in flight at a time: IDLE accepts, WAIT counts down, RESP commits and answers.
module data_mem_sync #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 64,
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int         CMP_W     = ((ADDR_W > 17) ? ADDR_W : 17) + 1;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              resp_valid_q;
    logic [DATA_W-1:0] resp_rdata_q;
    logic              resp_err_q;

    // Each word stores data XOR its power-up value, so a zero fill reads back as word 9 = 1, word 10 = 5.
    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};

    logic              enterResp_d;
    logic              accWrite_d;
    logic [ADDR_W-1:0] accAddr_d;
    logic [DATA_W-1:0] accWdata_d;
    logic [CMP_W-1:0]  accAddrExt_d;
    logic [IDX_W-1:0]  accIdx_d;
    logic              accInRange_d;
    logic [DATA_W-1:0] accInit_d;

    // With no wait states the access is committed on the accept edge, so use the live request fields.
    always_comb begin
        accWrite_d   = (state_q == IDLE) ? req_write : write_q;
        accAddr_d    = (state_q == IDLE) ? req_addr  : addr_q;
        accWdata_d   = (state_q == IDLE) ? req_wdata : wdata_q;
        enterResp_d  = rst_n && (((state_q == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                                 ((state_q == WAIT) && (cnt_q <= 4'd1)));
        accAddrExt_d = CMP_W'(accAddr_d);
        accIdx_d     = IDX_W'(accAddrExt_d);
        accInRange_d = accAddrExt_d < CMP_W'(DEPTH);
        accInit_d    = '0;
        if ((DEPTH > 10) && (32'(accIdx_d) == 9)) begin
            accInit_d = DATA_W'(1);
        end else if ((DEPTH > 10) && (32'(accIdx_d) == 10)) begin
            accInit_d = DATA_W'(5);
        end
    end

    always_ff @(posedge clk) begin
        if (enterResp_d && accWrite_d && accInRange_d) begin
            mem_q[accIdx_d] <= accWdata_d ^ accInit_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt_q   <= WAIT_LOAD;
                        state_q <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= err_q;
                    if (!write_q) begin
                        resp_rdata_q <= rdata_q;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (enterResp_d) begin
                rdata_q <= accInRange_d ? (mem_q[accIdx_d] ^ accInit_d) : '0;
                err_q   <= !accInRange_d;
            end
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: doc/data_mem_sync.md
DATA_MEM_SYNC -- requirements
Module: data_mem_sync

Interface
REQ-001 SHALL have parameter DATA_W, default 32: word width in bits.
REQ-002 SHALL have parameter DEPTH, default 64: number of words, any integer 2..65536.
REQ-003 SHALL have parameter ADDR_W, default 32: request address width.
REQ-004 SHALL have parameter WAIT_CYCLES, default 1: added access latency, range 0..15.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port req_valid, input, 1: request present.
REQ-008 SHALL have port req_ready, output, 1: block accepts a request this cycle.
REQ-009 SHALL have port req_write, input, 1: 1 = write, 0 = read.
REQ-010 SHALL have port req_addr, input, ADDR_W: word address (ALU result).
REQ-011 SHALL have port req_wdata, input, DATA_W: store data (regB value).
REQ-012 SHALL have port resp_valid, output, 1: one-cycle pulse marking completion.
REQ-013 SHALL have port resp_rdata, output, DATA_W: read data; held until next response.
REQ-014 SHALL have port resp_err, output, 1: completed access was out of range.

Function
REQ-015 SHALL accept a request on a rising edge where req_valid and req_ready are both 1; SHALL capture write, addr and wdata at that edge.
REQ-016 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; req_ready SHALL be 1 only in IDLE.
REQ-017 On acceptance SHALL load a wait counter with WAIT_CYCLES and enter WAIT; if WAIT_CYCLES = 0, SHALL go directly to RESP.
REQ-018 In WAIT SHALL decrement the counter each cycle and enter RESP on the cycle the counter reaches 0.
REQ-019 In RESP SHALL assert resp_valid for exactly one cycle, then return to IDLE; total latency from accept edge to resp_valid high SHALL be WAIT_CYCLES+1 cycles.
REQ-020 Read: resp_rdata SHALL equal the memory word at the captured address, sampled on entry to RESP.
REQ-021 Write: the memory word SHALL update on the edge entering RESP; resp_rdata SHALL be unchanged.
REQ-022 Address >= DEPTH SHALL set resp_err = 1 with that response; the write SHALL be suppressed and read data SHALL be 0.
REQ-023 resp_err SHALL be 0 on in-range responses and SHALL hold its value until the next response.
REQ-024 Only the low DATA_W bits of req_wdata SHALL be stored; address bits above ADDR_W SHALL NOT exist (no wrap-around; out-of-range per REQ-022).
REQ-025 Read-after-write to the same address, back-to-back, SHALL return the newly written value.
REQ-026 req_valid changes while not in IDLE SHALL be ignored; no request queueing.
REQ-027 Memory initial contents SHALL be all zero except word 9 = 1 and word 10 = 5 (when DEPTH > 10), applied at time zero only.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, counter 0, req_ready 1 after release, resp_valid 0, resp_rdata 0, resp_err 0.
REQ-029 Reset SHALL NOT alter memory contents.
REQ-030 Reset asserted during WAIT SHALL abort the access: a pending write SHALL NOT commit and no response SHALL be produced.

Verification
REQ-031 WAIT_CYCLES=1, read addr 10 -> resp_valid 2 cycles after accept, resp_rdata = 5, resp_err = 0.
REQ-032 Write addr 3 data 0xDEADBEEF, then read addr 3 -> resp_rdata = 0xDEADBEEF; req_ready low between accept and return to IDLE.
REQ-033 Read addr 64 with DEPTH=64 -> resp_err = 1, resp_rdata = 0; write to addr 64 leaves words 0..63 unchanged.
REQ-034 WAIT_CYCLES=0 and WAIT_CYCLES=15 -> latency exactly 1 and 16 cycles respectively; one resp_valid pulse per request.
REQ-035 Write addr 9 data 7, assert rst_n low during WAIT, release, read addr 9 -> resp_rdata = 1; outputs 0 during reset.
REQ-036 req_valid held high continuously with alternating read/write -> exactly one accept per IDLE visit, no dropped or duplicated responses.
